// File: rtl/noc_reset_pkg.sv
// ---------------------------------------------------------------------------
// noc_reset_pkg
// Shared types and constants for the NoC reset sequencer.
//   state_e        : sequencer states (HOLD, RELEASE, RUN, DRAIN, ASSERT)
//   DEF_*          : default parameter values
//   cnt_width()    : width of the shared delay counter, sized so the largest
//                    of the three programmable delays fits
// ---------------------------------------------------------------------------
package noc_reset_pkg;

   localparam int DEF_NUM_STAGES    = 4;
   localparam int DEF_STRETCH_CYCLES = 3;
   localparam int DEF_STAGE_GAP     = 2;
   localparam int DEF_DRAIN_TIMEOUT = 64;

   typedef enum logic [2:0] {
      ST_HOLD    = 3'd0,
      ST_RELEASE = 3'd1,
      ST_RUN     = 3'd2,
      ST_DRAIN   = 3'd3,
      ST_ASSERT  = 3'd4
   } state_e;

   function automatic int cnt_width(input int stretch, input int gap, input int timeout);
      int m;
      m = stretch;
      if (gap > m) m = gap;
      if (timeout > m) m = timeout;
      return $clog2(m + 1);
   endfunction

endpackage

// File: rtl/reset_delay_counter.sv
// ---------------------------------------------------------------------------
// reset_delay_counter
// Loadable down-counter that stops at zero instead of wrapping.
//   clk      : clock
//   rst      : synchronous active-high reset, clears the count
//   load     : load load_val this edge (has priority over counting)
//   load_val : value to load
//   zero     : count is currently zero
// ---------------------------------------------------------------------------
module reset_delay_counter #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic [W-1:0] load_val,
   output logic         zero
);

   logic [W-1:0] count_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         count_q <= '0;
      end else if (load) begin
         count_q <= load_val;
      end else if (count_q != '0) begin
         count_q <= count_q - 1'b1;
      end
   end

   assign zero = (count_q == '0);

endmodule

// File: rtl/noc_reset_sequencer.sv
// ---------------------------------------------------------------------------
// noc_reset_sequencer
// Releases the NoC per-stage resets one at a time after board reset, and runs
// the software soft-reset cycle (drain, re-assert, replay the release).
//   clk           : system clock
//   rst           : synchronous active-high board reset, overrides everything
//   soft_rst_req  : level request for a soft reset, only looked at in RUN
//   drain_req     : asks the NoC to stop injecting and empty its buffers
//   drain_ack     : NoC reports it is empty
//   soft_rst_ack  : one-cycle pulse on the cycle all stages are re-asserted
//   rst_stage     : per-stage reset, active-high, stage 0 released first
//   rst_done      : all stages released
//   drain_timeout : sticky, the last drain ended by timeout instead of ack
//   state_dbg     : current sequencer state
//
// Drain handshake: drain_req rises on entry to DRAIN and holds until the
// sequencer leaves DRAIN. drain_ack is sampled on every DRAIN edge; the first
// edge that sees it high ends the drain, even if the timeout expires on that
// same edge. Without ack, the drain ends after DRAIN_TIMEOUT edges.
// ---------------------------------------------------------------------------
module noc_reset_sequencer
   import noc_reset_pkg::*;
#(
   parameter int NUM_STAGES     = DEF_NUM_STAGES,
   parameter int STRETCH_CYCLES = DEF_STRETCH_CYCLES,
   parameter int STAGE_GAP      = DEF_STAGE_GAP,
   parameter int DRAIN_TIMEOUT  = DEF_DRAIN_TIMEOUT
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  soft_rst_req,
   output logic                  drain_req,
   input  logic                  drain_ack,
   output logic                  soft_rst_ack,
   output logic [NUM_STAGES-1:0] rst_stage,
   output logic                  rst_done,
   output logic                  drain_timeout,
   output state_e                state_dbg
);

   localparam int CW = cnt_width(STRETCH_CYCLES, STAGE_GAP, DRAIN_TIMEOUT);
   localparam int IW = $clog2(NUM_STAGES + 1);

   // Counter is loaded with N-1 so that it reads zero on the N-th edge after
   // the load edge.
   localparam logic [CW-1:0] LD_STRETCH = CW'(STRETCH_CYCLES - 1);
   localparam logic [CW-1:0] LD_GAP     = CW'(STAGE_GAP - 1);
   localparam logic [CW-1:0] LD_DRAIN   = CW'(DRAIN_TIMEOUT - 1);
   localparam logic [NUM_STAGES-1:0] ALL_ONES = '1;

   state_e                state_q, state_d;
   logic [NUM_STAGES-1:0] stage_q, stage_d;
   logic [IW-1:0]         idx_q, idx_d;
   logic                  done_q, done_d;
   logic                  dreq_q, dreq_d;
   logic                  sack_q, sack_d;
   logic                  tout_q, tout_d;
   // HOLD needs one edge to arm the stretch count when entered from board
   // reset, because the counter comes out of reset at zero.
   logic                  armed_q, armed_d;

   logic                  cnt_load;
   logic [CW-1:0]         cnt_val;
   logic                  cnt_zero;

   reset_delay_counter #(.W(CW)) u_delay (
      .clk      (clk),
      .rst      (rst),
      .load     (cnt_load),
      .load_val (cnt_val),
      .zero     (cnt_zero)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_HOLD;
         stage_q <= ALL_ONES;
         idx_q   <= '0;
         done_q  <= 1'b0;
         dreq_q  <= 1'b0;
         sack_q  <= 1'b0;
         tout_q  <= 1'b0;
         armed_q <= 1'b0;
      end else begin
         state_q <= state_d;
         stage_q <= stage_d;
         idx_q   <= idx_d;
         done_q  <= done_d;
         dreq_q  <= dreq_d;
         sack_q  <= sack_d;
         tout_q  <= tout_d;
         armed_q <= armed_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      stage_d  = stage_q;
      idx_d    = idx_q;
      done_d   = done_q;
      dreq_d   = dreq_q;
      sack_d   = 1'b0;
      tout_d   = tout_q;
      armed_d  = armed_q;
      cnt_load = 1'b0;
      cnt_val  = '0;
      case (state_q)
         ST_HOLD: begin
            if (!armed_q) begin
               cnt_load = 1'b1;
               cnt_val  = LD_STRETCH;
               armed_d  = 1'b1;
            end else if (cnt_zero) begin
               state_d  = ST_RELEASE;
               stage_d  = ALL_ONES << 1;
               idx_d    = IW'(1);
               cnt_load = 1'b1;
               cnt_val  = LD_GAP;
               armed_d  = 1'b0;
            end
         end
         ST_RELEASE: begin
            if (idx_q == IW'(NUM_STAGES)) begin
               state_d = ST_RUN;
               done_d  = 1'b1;
            end else if (cnt_zero) begin
               // Stages below idx+1 are released; the mask only ever shrinks.
               stage_d  = ALL_ONES << (idx_q + 1'b1);
               idx_d    = idx_q + 1'b1;
               cnt_load = 1'b1;
               cnt_val  = LD_GAP;
            end
         end
         ST_RUN: begin
            if (soft_rst_req) begin
               state_d  = ST_DRAIN;
               dreq_d   = 1'b1;
               tout_d   = 1'b0;
               cnt_load = 1'b1;
               cnt_val  = LD_DRAIN;
            end
         end
         ST_DRAIN: begin
            if (drain_ack || cnt_zero) begin
               state_d = ST_ASSERT;
               stage_d = ALL_ONES;
               done_d  = 1'b0;
               dreq_d  = 1'b0;
               sack_d  = 1'b1;
               tout_d  = !drain_ack;
            end
         end
         ST_ASSERT: begin
            // The exit edge is the start of the stretch, so arm here.
            state_d  = ST_HOLD;
            idx_d    = '0;
            armed_d  = 1'b1;
            cnt_load = 1'b1;
            cnt_val  = LD_STRETCH;
         end
         default: begin
            state_d = ST_HOLD;
         end
      endcase
   end

   assign rst_stage     = stage_q;
   assign rst_done      = done_q;
   assign drain_req     = dreq_q;
   assign soft_rst_ack  = sack_q;
   assign drain_timeout = tout_q;
   assign state_dbg     = state_q;

endmodule
